// File: rtl/axi_lite_global_scheduler.sv
// AXI-Lite register block and job dispatcher for a bank of kernel slots.
// Tracks per-kernel busy state, raises per-kernel completion interrupts and
// hands each job_start to an idle kernel (fixed priority or round-robin).
module axi_lite_global_scheduler #(
  parameter int KERNEL_NUM = 8,
  parameter int ARB_MODE   = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [31:0]           i_action_type,
  input  logic                  job_start,
  input  logic [KERNEL_NUM-1:0] kernel_complete,
  output logic [KERNEL_NUM-1:0] kernel_start,
  output logic                  manager_start,
  output logic [63:0]           init_addr,
  output logic                  new_job,
  output logic                  job_done,
  output logic                  o_interrupt
);

  localparam int PW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(KERNEL_NUM - 1);

  localparam logic [ADDR_WIDTH-1:0] A_ACTION = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(32'h30);
  localparam logic [ADDR_WIDTH-1:0] A_ENABLE = ADDR_WIDTH'(32'h34);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(32'h38);
  localparam logic [ADDR_WIDTH-1:0] A_HI     = ADDR_WIDTH'(32'h3C);
  localparam logic [ADDR_WIDTH-1:0] A_LO     = ADDR_WIDTH'(32'h40);
  localparam logic [ADDR_WIDTH-1:0] A_DONE   = ADDR_WIDTH'(32'h44);
  localparam logic [ADDR_WIDTH-1:0] A_BUSY   = ADDR_WIDTH'(32'h48);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT  = ADDR_WIDTH'(32'h4C);
  localparam logic [ADDR_WIDTH-1:0] A_ERR    = ADDR_WIDTH'(32'h50);

  function automatic logic [31:0] zext(input logic [KERNEL_NUM-1:0] v);
    logic [31:0] r;
    r = '0;
    r[KERNEL_NUM-1:0] = v;
    return r;
  endfunction

  // AXI handshake state
  logic        aw_ready_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  // register file and scheduler state
  logic [KERNEL_NUM-1:0] status_q, status_d;
  logic [KERNEL_NUM-1:0] enable_q, enable_d;
  logic                  ctrl_q, ctrl_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           count_q, count_d;
  logic                  err_q, err_d;
  logic [KERNEL_NUM-1:0] busy_q, busy_d;
  logic [KERNEL_NUM-1:0] kstart_q;
  logic                  irq_q;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [KERNEL_NUM-1:0] prev_q;

  logic                  wr_fire, ar_fire;
  logic [31:0]           wmask, wbits;
  logic [KERNEL_NUM-1:0] wmask_k, wbits_k;
  logic [KERNEL_NUM-1:0] cpl_edge;
  logic [31:0]           edge_cnt;
  logic                  found;
  logic [PW-1:0]         sel_idx;
  logic [KERNEL_NUM-1:0] grant;
  logic                  drop;
  logic [31:0]           rd_mux;

  assign wr_fire  = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
  assign ar_fire  = s_axi_arvalid & ~rvalid_q;
  assign wmask    = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                     {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wbits    = s_axi_wdata & wmask;
  assign wmask_k  = wmask[KERNEL_NUM-1:0];
  assign wbits_k  = wbits[KERNEL_NUM-1:0];
  // prev_q resets to all ones so a level already high out of reset is not a completion
  assign cpl_edge = kernel_complete & ~prev_q;

  // number of kernels completing this cycle
  always_comb begin
    edge_cnt = '0;
    for (int i = 0; i < KERNEL_NUM; i++) edge_cnt = edge_cnt + 32'(cpl_edge[i]);
  end

  // pick an idle kernel for a pending job_start
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    found   = 1'b0;
    sel_idx = ptr_q;
    idx     = 0;
    idx_p   = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < KERNEL_NUM; i++) begin
        idx_p = PW'(i);
        if (!busy_q[idx_p]) begin
          found   = 1'b1;
          sel_idx = idx_p;
        end
      end
    end else begin
      for (int off = 1; off <= KERNEL_NUM; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= KERNEL_NUM) idx = idx - KERNEL_NUM;
        idx_p = PW'(idx);
        if (!found && !busy_q[idx_p]) begin
          found   = 1'b1;
          sel_idx = idx_p;
        end
      end
    end
    for (int i = 0; i < KERNEL_NUM; i++) grant[i] = job_start & found & (sel_idx == PW'(i));
    drop = job_start & ~found;
  end

  // next-state for registers; completion sets beat W1C clears, grants beat completions
  always_comb begin
    status_d = status_q;
    if (wr_fire && s_axi_awaddr == A_STATUS) status_d = status_d & ~wbits_k;
    status_d = status_d | cpl_edge;

    enable_d = enable_q;
    if (wr_fire && s_axi_awaddr == A_ENABLE) enable_d = (enable_q & ~wmask_k) | wbits_k;

    ctrl_d = ctrl_q;
    if (wr_fire && s_axi_awaddr == A_CTRL && s_axi_wstrb[0]) ctrl_d = s_axi_wdata[0];

    hi_d = hi_q;
    if (wr_fire && s_axi_awaddr == A_HI) hi_d = (hi_q & ~wmask) | wbits;
    lo_d = lo_q;
    if (wr_fire && s_axi_awaddr == A_LO) lo_d = (lo_q & ~wmask) | wbits;

    count_d = count_q + edge_cnt;
    if (wr_fire && s_axi_awaddr == A_CTRL && wbits[1]) count_d = '0;

    err_d = err_q;
    if (wr_fire && s_axi_awaddr == A_ERR && wbits[0]) err_d = 1'b0;
    if (drop) err_d = 1'b1;

    busy_d = (busy_q & ~cpl_edge) | grant;
    ptr_d  = (|grant) ? sel_idx : ptr_q;
  end

  // read data decode
  always_comb begin
    case (s_axi_araddr)
      A_ACTION: rd_mux = i_action_type;
      A_STATUS: rd_mux = zext(status_q);
      A_ENABLE: rd_mux = zext(enable_q);
      A_CTRL:   rd_mux = {31'b0, ctrl_q};
      A_HI:     rd_mux = hi_q;
      A_LO:     rd_mux = lo_q;
      A_DONE:   rd_mux = {31'b0, job_done};
      A_BUSY:   rd_mux = zext(busy_q);
      A_COUNT:  rd_mux = count_q;
      A_ERR:    rd_mux = {31'b0, err_q};
      default:  rd_mux = 32'h5A5A_A5A5;
    endcase
  end

  // AXI-Lite write/read handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (aw_ready_q) aw_ready_q <= 1'b0;
      else if (s_axi_awvalid && s_axi_wvalid && !bvalid_q) aw_ready_q <= 1'b1;

      if (wr_fire) bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;

      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // register file, busy tracking, dispatch and interrupt update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      enable_q <= '0;
      ctrl_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= '0;
      kstart_q <= '0;
      irq_q    <= 1'b0;
      ptr_q    <= PTR_RST;
      prev_q   <= '1;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      ctrl_q   <= ctrl_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      kstart_q <= grant;
      irq_q    <= |(status_q & enable_q);
      ptr_q    <= ptr_d;
      prev_q   <= kernel_complete;
    end
  end

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = aw_ready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign kernel_start  = kstart_q;
  assign manager_start = ctrl_q;
  assign init_addr     = {hi_q, lo_q};
  assign new_job       = ~&busy_q;
  assign job_done      = ~|busy_q;
  assign o_interrupt   = irq_q;

endmodule

// File: tb/tb_axi_lite_global_scheduler.sv
// Bench for axi_lite_global_scheduler: one round-robin and one fixed-priority
// instance share every input; register vectors, directed corner sequences and
// a randomized run against a behavioural model.
module tb_axi_lite_global_scheduler;
  localparam int KN = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr, action;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready, job_start;
  logic [7:0]  kc;

  logic        awready1, wready1, bvalid1, arready1, rvalid1, ms1, nj1, jd1, irq1;
  logic [1:0]  bresp1, rresp1;
  logic [31:0] rdata1;
  logic [7:0]  ks1;
  logic [63:0] ia1;
  logic        awready0, wready0, bvalid0, arready0, rvalid0, ms0, nj0, jd0, irq0;
  logic [1:0]  bresp0, rresp0;
  logic [31:0] rdata0;
  logic [7:0]  ks0;
  logic [63:0] ia0;

  axi_lite_global_scheduler #(.KERNEL_NUM(KN), .ARB_MODE(1), .ADDR_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready1),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready1),
    .s_axi_bresp(bresp1), .s_axi_bvalid(bvalid1), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready1),
    .s_axi_rdata(rdata1), .s_axi_rresp(rresp1), .s_axi_rvalid(rvalid1), .s_axi_rready(rready),
    .i_action_type(action), .job_start(job_start), .kernel_complete(kc),
    .kernel_start(ks1), .manager_start(ms1), .init_addr(ia1),
    .new_job(nj1), .job_done(jd1), .o_interrupt(irq1));

  axi_lite_global_scheduler #(.KERNEL_NUM(KN), .ARB_MODE(0), .ADDR_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready0),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready0),
    .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready0),
    .s_axi_rdata(rdata0), .s_axi_rresp(rresp0), .s_axi_rvalid(rvalid0), .s_axi_rready(rready),
    .i_action_type(action), .job_start(job_start), .kernel_complete(kc),
    .kernel_start(ks0), .manager_start(ms0), .init_addr(ia0),
    .new_job(nj0), .job_done(jd0), .o_interrupt(irq0));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[18];

  // behavioural model state for the randomized run
  logic [7:0]  m_busy1, m_busy0, m_status, m_prev, m_en, m_edges, e_ks1, e_ks0;
  logic        m_err1, m_err0, e_irq;
  logic [31:0] m_count;
  int          m_last;
  logic [31:0] r1, r0;
  logic [7:0]  exp_a1[4], exp_a0[4], exp_b1[4], exp_b0[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    job_start = 1'b0; kc = '0;
    tick; tick;
    rst = 1'b0;
    tick; tick;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic use_kc, input logic [7:0] kc_hs);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick; n++; end while (!awready1 && n < 20);
    chk("awready_seen", 64'({awready1, wready1, awready0, wready0}), 64'hF);
    if (use_kc) kc = kc_hs;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_rise", 64'({bvalid1, bvalid0, bresp1, bresp0, awready1}), 64'b11_0000_0);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_drop", 64'({bvalid1, bvalid0}), 64'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_write(a, d, s, 1'b0, 8'h00);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d0);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready1 && n < 20) begin tick; n++; end
    chk("arready_seen", 64'(arready1), 64'h1);
    tick;
    arvalid = 1'b0;
    chk("rvalid_rise", 64'({rvalid1, rvalid0, rresp1, rresp0, arready1}), 64'b11_0000_0);
    d1 = rdata1; d0 = rdata0;
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] e1, input logic [31:0] e0);
    logic [31:0] d1, d0;
    axi_read(a, d1, d0);
    chk({name, "_rr"}, 64'(d1), 64'(e1));
    chk({name, "_fix"}, 64'(d0), 64'(e0));
  endtask

  initial begin
    action = 32'h1014_0000;
    tbl[0]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h1014_0000};
    tbl[1]  = '{1'b0, 32'h60, 32'h0,         4'h0, 32'h5A5A_A5A5};
    tbl[2]  = '{1'b1, 32'h34, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 32'h34, 32'h0,         4'h0, 32'h0000_00FF};
    tbl[4]  = '{1'b1, 32'h3C, 32'h1234_5678, 4'hF, 32'h0};
    tbl[5]  = '{1'b0, 32'h3C, 32'h0,         4'h0, 32'h1234_5678};
    tbl[6]  = '{1'b1, 32'h40, 32'hAABB_CCDD, 4'h5, 32'h0};
    tbl[7]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'h00BB_00DD};
    tbl[8]  = '{1'b1, 32'h38, 32'h0000_0001, 4'h1, 32'h0};
    tbl[9]  = '{1'b0, 32'h38, 32'h0,         4'h0, 32'h0000_0001};
    tbl[10] = '{1'b0, 32'h44, 32'h0,         4'h0, 32'h0000_0001};
    tbl[11] = '{1'b0, 32'h48, 32'h0,         4'h0, 32'h0};
    tbl[12] = '{1'b1, 32'h70, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[13] = '{1'b0, 32'h70, 32'h0,         4'h0, 32'h5A5A_A5A5};
    tbl[14] = '{1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[15] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h1014_0000};
    tbl[16] = '{1'b1, 32'h34, 32'h0,         4'h2, 32'h0};
    tbl[17] = '{1'b0, 32'h34, 32'h0,         4'h0, 32'h0000_00FF};
    exp_a1 = '{8'h01, 8'h02, 8'h04, 8'h08};
    exp_a0 = '{8'h80, 8'h40, 8'h20, 8'h10};
    exp_b1 = '{8'h10, 8'h20, 8'h40, 8'h80};
    exp_b0 = '{8'h08, 8'h04, 8'h02, 8'h01};

    // reset values
    do_reset;
    chk("rst_axi", 64'({awready1, wready1, bvalid1, rvalid1, arready1,
                        awready0, wready0, bvalid0, rvalid0, arready0}), 64'b00001_00001);
    chk("rst_rdata", 64'({rdata1, rdata0}), 64'h0);
    chk("rst_kstart", 64'({ks1, ks0}), 64'h0);
    chk("rst_status", 64'({irq1, irq0, ms1, ms0, nj1, nj0, jd1, jd0}), 64'b0000_1111);
    chk("rst_init_addr", ia1 | ia0, 64'h0);

    // register map vectors
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, tbl[i].strb);
      else rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp, tbl[i].exp);
    end
    chk("init_addr", ia1, 64'h1234_5678_00BB_00DD);
    chk("manager_start", 64'({ms1, ms0}), 64'h3);

    // reset aborts an in-flight write and read
    awaddr = 32'h3C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick; tick;
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0;
    tick;
    rst = 1'b0;
    tick; tick;
    chk("abort_wr_bvalid", 64'({bvalid1, bvalid0}), 64'h0);
    rd_chk("abort_wr_hi", 32'h3C, 32'h0, 32'h0);
    araddr = 32'h10; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick; tick;
    chk("abort_rd_rvalid", 64'({rvalid1, rvalid0, rdata1}), 64'h0);

    // consecutive dispatches until every kernel is busy, then a dropped request
    do_reset;
    job_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("grantA%0d_rr", i), 64'(ks1), 64'(exp_a1[i]));
      chk($sformatf("grantA%0d_fix", i), 64'(ks0), 64'(exp_a0[i]));
    end
    job_start = 1'b0;
    tick;
    chk("kstart_single", 64'({ks1, ks0}), 64'h0);
    chk("newjob_part", 64'({nj1, jd1}), 64'b10);
    rd_chk("busy_half", 32'h48, 32'h0F, 32'hF0);
    job_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("grantB%0d_rr", i), 64'(ks1), 64'(exp_b1[i]));
      chk($sformatf("grantB%0d_fix", i), 64'(ks0), 64'(exp_b0[i]));
    end
    job_start = 1'b0;
    tick;
    chk("newjob_full", 64'({nj1, jd1, nj0, jd0}), 64'h0);
    job_start = 1'b1;
    tick;
    job_start = 1'b0;
    chk("drop_kstart", 64'({ks1, ks0}), 64'h0);
    rd_chk("err_set", 32'h50, 32'h1, 32'h1);
    wr(32'h50, 32'h1, 4'h1);
    rd_chk("err_clr", 32'h50, 32'h0, 32'h0);
    rd_chk("busy_full", 32'h48, 32'hFF, 32'hFF);

    // completion interrupt, latency and byte-masked W1C
    do_reset;
    wr(32'h34, 32'h04, 4'hF);
    kc = 8'h04;
    tick;
    chk("irq_latency", 64'(irq1), 64'h0);
    tick;
    chk("irq_set", 64'({irq1, irq0}), 64'h3);
    rd_chk("status_k2", 32'h30, 32'h04, 32'h04);
    rd_chk("count_1", 32'h4C, 32'h1, 32'h1);
    wr(32'h30, 32'h04, 4'h2);
    rd_chk("w1c_masked", 32'h30, 32'h04, 32'h04);
    chk("irq_hold", 64'(irq1), 64'h1);
    wr(32'h30, 32'h04, 4'h1);
    chk("irq_clr", 64'({irq1, irq0}), 64'h0);
    rd_chk("status_clr", 32'h30, 32'h0, 32'h0);
    kc = 8'h06;
    tick; tick;
    chk("irq_masked", 64'(irq1), 64'h0);
    rd_chk("status_k1", 32'h30, 32'h02, 32'h02);
    rd_chk("count_2", 32'h4C, 32'h2, 32'h2);

    // W1C coincident with a completion edge: set wins
    do_reset;
    kc = 8'h08;
    tick;
    kc = 8'h00;
    tick;
    rd_chk("status_k3", 32'h30, 32'h08, 32'h08);
    axi_write(32'h30, 32'h08, 4'hF, 1'b1, 8'h08);
    rd_chk("set_wins", 32'h30, 32'h08, 32'h08);
    rd_chk("count_edges", 32'h4C, 32'h2, 32'h2);
    wr(32'h30, 32'h08, 4'hF);
    rd_chk("w1c_plain", 32'h30, 32'h0, 32'h0);

    // fixed priority skips the busy top kernel; job count clear
    do_reset;
    job_start = 1'b1;
    tick;
    chk("fix_first", 64'({ks1, ks0}), 64'h01_80);
    tick;
    job_start = 1'b0;
    chk("fix_second", 64'({ks1, ks0}), 64'h02_40);
    rd_chk("busy_c0", 32'h48, 32'h03, 32'hC0);
    kc = 8'h01;
    tick;
    rd_chk("count_pre", 32'h4C, 32'h1, 32'h1);
    rd_chk("busy_after_cpl", 32'h48, 32'h02, 32'hC0);
    wr(32'h38, 32'h3, 4'h1);
    rd_chk("count_cleared", 32'h4C, 32'h0, 32'h0);
    rd_chk("ctrl_bit0_only", 32'h38, 32'h1, 32'h1);
    chk("mstart_on", 64'({ms1, ms0}), 64'h3);

    // randomized dispatch/completion traffic against the model
    do_reset;
    wr(32'h34, 32'hFF, 4'h1);
    m_busy1 = '0; m_busy0 = '0; m_status = '0; m_prev = '0; m_en = 8'hFF;
    m_err1 = 1'b0; m_err0 = 1'b0; m_count = '0; m_last = KN - 1;
    for (int c = 0; c < 800; c++) begin
      job_start = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) kc = kc ^ 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 1) == 0) kc = kc ^ 8'(1 << $urandom_range(0, 7));
      m_edges = kc & ~m_prev;
      e_ks1 = '0; e_ks0 = '0;
      if (job_start) begin
        for (int off = 1; off <= KN; off++) begin
          int k;
          k = (m_last + off) % KN;
          if (e_ks1 == 0 && !m_busy1[k]) begin e_ks1[k] = 1'b1; m_last = k; end
        end
        for (int k = KN - 1; k >= 0; k--)
          if (e_ks0 == 0 && !m_busy0[k]) e_ks0[k] = 1'b1;
        if (e_ks1 == 0) m_err1 = 1'b1;
        if (e_ks0 == 0) m_err0 = 1'b1;
      end
      m_busy1 = (m_busy1 & ~m_edges) | e_ks1;
      m_busy0 = (m_busy0 & ~m_edges) | e_ks0;
      e_irq = |(m_status & m_en);
      m_status = m_status | m_edges;
      m_count = m_count + 32'($countones(m_edges));
      m_prev = kc;
      tick;
      chk("rnd_kstart_rr", 64'(ks1), 64'(e_ks1));
      chk("rnd_kstart_fix", 64'(ks0), 64'(e_ks0));
      chk("rnd_irq", 64'({irq1, irq0}), 64'({e_irq, e_irq}));
      chk("rnd_flags", 64'({nj1, jd1, nj0, jd0}),
          64'({~&m_busy1, ~|m_busy1, ~&m_busy0, ~|m_busy0}));
    end
    job_start = 1'b0;
    tick;
    rd_chk("rnd_count", 32'h4C, m_count, m_count);
    rd_chk("rnd_busy", 32'h48, 32'(m_busy1), 32'(m_busy0));
    rd_chk("rnd_status", 32'h30, 32'(m_status), 32'(m_status));
    rd_chk("rnd_err", 32'h50, 32'(m_err1), 32'(m_err0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_global_scheduler.md
AXI_LITE_GLOBAL_SCHEDULER -- requirements
Module: axi_lite_global_scheduler

Interface
REQ-001 SHALL have parameter KERNEL_NUM, default 8, number of kernel slots (legal 1..32).
REQ-002 SHALL have parameter ARB_MODE, default 1, 0 = fixed priority (highest index first), 1 = round-robin.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width; data width fixed at 32.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 s_axi_aw*/w*/b*/ar*/r*  AXI-Lite slave  awaddr/araddr ADDR_WIDTH, wdata/rdata 32, wstrb 4, bresp/rresp 2 (tied 0).
REQ-008 i_action_type  in  32  value returned at 0x10.
REQ-009 job_start  in  1  single-cycle dispatch request.
REQ-010 kernel_complete  in  KERNEL_NUM  per-kernel level done; rising edge = completion.
REQ-011 kernel_start  out  KERNEL_NUM  one-hot single-cycle start pulse.
REQ-012 manager_start, init_addr[63:0], new_job, job_done, o_interrupt  out  control/status, per Function.

Function
REQ-013 Write: awready and wready SHALL pulse together for one cycle when awvalid & wvalid & ~bvalid; bvalid SHALL rise next cycle and hold until bready.
REQ-014 Read: arready SHALL be high while rvalid low; rdata/rvalid SHALL be registered one cycle after ar handshake, held until rready.
REQ-015 wstrb SHALL mask writes per byte; unmasked bytes keep their old value (W1C: unmasked bytes clear nothing).
REQ-016 Register map: 0x10 action type RO; 0x30 INTR_STATUS W1C; 0x34 INTR_ENABLE RW; 0x38 GLOBAL_CONTROL RW; 0x3C INIT_ADDR_HI RW; 0x40 INIT_ADDR_LO RW; 0x44 DONE RO {31'b0,job_done}; 0x48 KERNEL_BUSY RO; 0x4C JOB_COUNT RO; 0x50 ERR W1C bit0 dispatch-drop.
REQ-017 Unmapped reads SHALL return 0x5A5AA5A5; unmapped writes SHALL be ignored but still respond OKAY.
REQ-018 Bits at or above KERNEL_NUM in per-kernel registers SHALL read 0 and ignore writes.
REQ-019 manager_start = GLOBAL_CONTROL[0]; init_addr = {HI,LO}.
REQ-020 Writing 1 to GLOBAL_CONTROL[1] SHALL clear JOB_COUNT; bit 1 self-clears and reads 0.
REQ-021 Completion edge detect: prev register reset to all ones; edge = ~prev & kernel_complete.
REQ-022 Edge on kernel k SHALL set INTR_STATUS[k], clear busy[k], increment JOB_COUNT by popcount of edges (mod 2^32) next cycle.
REQ-023 Edge and W1C on same bit same cycle: set SHALL win.
REQ-024 o_interrupt SHALL be registered |(INTR_STATUS & INTR_ENABLE), one cycle after status/enable change.
REQ-025 new_job = ~&busy; job_done = ~|busy (combinational from busy).
REQ-026 job_start with idle kernel: next cycle kernel_start SHALL be one-hot on selected idle kernel for exactly one cycle, and busy for it set at the same edge.
REQ-027 ARB_MODE 0: select highest-index idle kernel. ARB_MODE 1: search starts at last-granted+1 modulo KERNEL_NUM, downward-free wrap; pointer resets to KERNEL_NUM-1 so first grant is kernel 0.
REQ-028 job_start with all kernels busy: kernel_start SHALL stay 0, ERR[0] SHALL set; request is dropped.
REQ-029 Edge on kernel k in the same cycle it is granted: busy set SHALL win.
REQ-030 Consecutive job_start cycles SHALL each dispatch to a different kernel using busy state including the previous grant.

Reset
REQ-031 On rst: all registers 0, busy 0, kernel_start 0, o_interrupt 0, bvalid/rvalid 0, awready/wready 0, arready 1, rdata 0, RR pointer KERNEL_NUM-1, prev all ones.
REQ-032 Reset mid-transaction SHALL abort it; no response issued afterwards for it.

Verification
REQ-033 Reset, read 0x10 with i_action_type=0x10140000 -> rdata 0x10140000; read 0x60 -> 0x5A5AA5A5.
REQ-034 ARB_MODE 1, KERNEL_NUM 8: four job_start pulses -> kernel_start 0x01,0x02,0x04,0x08; KERNEL_BUSY=0x0F, new_job 1, job_done 0.
REQ-035 Busy 0xFF, job_start -> no kernel_start, ERR=0x1; write 0x1 to 0x50 -> ERR=0.
REQ-036 INTR_ENABLE=0x04, kernel 2 completes -> INTR_STATUS=0x04, o_interrupt 1, JOB_COUNT 1; W1C 0x04 with wstrb 0x1 -> status 0, o_interrupt 0 next cycle.
REQ-037 W1C of bit 3 coincident with kernel-3 edge -> INTR_STATUS[3] remains 1.
REQ-038 ARB_MODE 0, busy 0x80 -> job_start grants 0x40; write 0x2 to 0x38 -> JOB_COUNT 0, 0x38 reads manager_start bit only.
